// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: accepts one decoded memory op from execute, aligns byte lanes onto a
// valid/ready memory bus, and returns a registered, extended writeback result.
module ysyx_23060332_lsu #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_is_load,
   input  logic        in_is_store,
   input  logic [2:0]  in_func3,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [4:0]  in_waddr,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic        wb_wen,
   output logic [4:0]  wb_waddr,
   output logic [31:0] wb_wdata,
   output logic        wb_err
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // the valid side holds its payload stable and valid high until that edge.
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

   localparam logic [31:0] TIMEOUT = 32'(TIMEOUT_CYC);

   state_t      state, state_nxt;
   logic        op_load;
   logic [2:0]  op_f3;
   logic [1:0]  op_lo;
   logic [4:0]  op_waddr;
   logic [31:0] wdog;

   logic        take, both, f3_ok, misal, bad, timeout;
   logic [3:0]  lane_mask;
   logic [31:0] rd_shift, ld_data;

   logic        in_ready_nxt, mem_req_valid_nxt, mem_wen_nxt;
   logic [31:0] mem_addr_nxt, mem_wdata_nxt;
   logic [7:0]  mem_wmask_nxt;
   logic        wb_valid_nxt, wb_wen_nxt, wb_err_nxt;
   logic [4:0]  wb_waddr_nxt;
   logic [31:0] wb_wdata_nxt;

   // Decode of the offered op and of the returning read word.
   always_comb begin
      take  = in_valid && in_ready && (in_is_load || in_is_store);
      both  = in_is_load && in_is_store;
      f3_ok = in_is_load ? (in_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                         : (in_func3 inside {3'b000, 3'b001, 3'b010});
      misal = (in_func3[1:0] == 2'b01 && in_addr[0]) ||
              (in_func3[1:0] == 2'b10 && in_addr[1:0] != 2'b00);
      bad   = both || !f3_ok || misal;
      case (in_func3[1:0])
         2'b00:   lane_mask = 4'b0001;
         2'b01:   lane_mask = 4'b0011;
         default: lane_mask = 4'b1111;
      endcase
      timeout  = (TIMEOUT != 32'd0) && (wdog >= TIMEOUT - 32'd1);
      rd_shift = mem_rdata >> {op_lo, 3'b000};
      case (op_f3)
         3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b100:  ld_data = {24'd0, rd_shift[7:0]};
         3'b101:  ld_data = {16'd0, rd_shift[15:0]};
         default: ld_data = rd_shift;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (take) state_nxt = bad ? RESP : REQ;
         REQ:  if (timeout) state_nxt = RESP;
               else if (mem_req_ready) state_nxt = WAIT;
         WAIT: if (mem_resp_valid || timeout) state_nxt = RESP;
         RESP: if (wb_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready_nxt      = in_ready;
      mem_req_valid_nxt = mem_req_valid;
      mem_wen_nxt       = mem_wen;
      mem_addr_nxt      = mem_addr;
      mem_wdata_nxt     = mem_wdata;
      mem_wmask_nxt     = mem_wmask;
      wb_valid_nxt      = wb_valid;
      wb_wen_nxt        = wb_wen;
      wb_waddr_nxt      = wb_waddr;
      wb_wdata_nxt      = wb_wdata;
      wb_err_nxt        = wb_err;
      case (state)
         IDLE: if (take) begin
            in_ready_nxt = 1'b0;
            if (bad) begin
               wb_valid_nxt = 1'b1;
               wb_err_nxt   = 1'b1;
               wb_wen_nxt   = 1'b0;
               wb_waddr_nxt = in_waddr;
               wb_wdata_nxt = 32'd0;
            end else begin
               mem_req_valid_nxt = 1'b1;
               mem_wen_nxt       = in_is_store;
               mem_addr_nxt      = {in_addr[31:2], 2'b00};
               mem_wdata_nxt     = in_is_store ? (in_wdata << {in_addr[1:0], 3'b000}) : 32'd0;
               mem_wmask_nxt     = in_is_store ? {4'b0000, lane_mask << in_addr[1:0]} : 8'd0;
            end
         end
         REQ: begin
            if (timeout) begin
               mem_req_valid_nxt = 1'b0;
               wb_valid_nxt      = 1'b1;
               wb_err_nxt        = 1'b1;
               wb_wen_nxt        = 1'b0;
               wb_waddr_nxt      = op_waddr;
               wb_wdata_nxt      = 32'd0;
            end else if (mem_req_ready) begin
               mem_req_valid_nxt = 1'b0;
            end
         end
         WAIT: begin
            // A response that lands in the timeout cycle still counts as on time.
            if (mem_resp_valid) begin
               wb_valid_nxt = 1'b1;
               wb_err_nxt   = 1'b0;
               wb_wen_nxt   = op_load && (op_waddr != 5'd0);
               wb_waddr_nxt = op_waddr;
               wb_wdata_nxt = op_load ? ld_data : 32'd0;
            end else if (timeout) begin
               wb_valid_nxt = 1'b1;
               wb_err_nxt   = 1'b1;
               wb_wen_nxt   = 1'b0;
               wb_waddr_nxt = op_waddr;
               wb_wdata_nxt = 32'd0;
            end
         end
         RESP: if (wb_ready) begin
            wb_valid_nxt = 1'b0;
            in_ready_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready      <= 1'b1;
         mem_req_valid <= 1'b0;
         mem_wen       <= 1'b0;
         mem_addr      <= 32'd0;
         mem_wdata     <= 32'd0;
         mem_wmask     <= 8'd0;
         wb_valid      <= 1'b0;
         wb_wen        <= 1'b0;
         wb_waddr      <= 5'd0;
         wb_wdata      <= 32'd0;
         wb_err        <= 1'b0;
         op_load       <= 1'b0;
         op_f3         <= 3'd0;
         op_lo         <= 2'd0;
         op_waddr      <= 5'd0;
         wdog          <= 32'd0;
      end else begin
         in_ready      <= in_ready_nxt;
         mem_req_valid <= mem_req_valid_nxt;
         mem_wen       <= mem_wen_nxt;
         mem_addr      <= mem_addr_nxt;
         mem_wdata     <= mem_wdata_nxt;
         mem_wmask     <= mem_wmask_nxt;
         wb_valid      <= wb_valid_nxt;
         wb_wen        <= wb_wen_nxt;
         wb_waddr      <= wb_waddr_nxt;
         wb_wdata      <= wb_wdata_nxt;
         wb_err        <= wb_err_nxt;
         if (take) begin
            op_load  <= in_is_load;
            op_f3    <= in_func3;
            op_lo    <= in_addr[1:0];
            op_waddr <= in_waddr;
         end
         if (state == IDLE && take && !bad)  wdog <= 32'd0;
         else if (state == REQ || state == WAIT) wdog <= wdog + 32'd1;
      end
   end

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Bench for ysyx_23060332_lsu: directed vector table, randomized ops checked against a
// behavioural model, and hand sequences for back-pressure, timeout and reset.
`timescale 1ns/1ps
module tb_ysyx_23060332_lsu;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, in_is_load = 1'b0, in_is_store = 1'b0;
   logic [2:0]  in_func3 = 3'd0;
   logic [31:0] in_addr = 32'd0, in_wdata = 32'd0;
   logic [4:0]  in_waddr = 5'd0;
   logic        mem_req_valid, mem_req_ready = 1'b0, mem_wen;
   logic [31:0] mem_addr, mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        wb_valid, wb_ready = 1'b0, wb_wen, wb_err;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;

   always #5 clk = ~clk;

   ysyx_23060332_lsu #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
      .in_is_store(in_is_store), .in_func3(in_func3), .in_addr(in_addr),
      .in_wdata(in_wdata), .in_waddr(in_waddr),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
      .wb_wdata(wb_wdata), .wb_err(wb_err)
   );

   typedef struct packed {
      logic ld; logic st; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata;
      logic [4:0] waddr; logic [31:0] rdata; int req_dly; int resp_dly; int wb_dly; logic early;
   } op_t;
   typedef struct packed {
      logic req; logic [31:0] maddr; logic mwen; logic [31:0] mwdata; logic [7:0] mmask;
      logic err; logic wwen; logic [31:0] wdata;
   } exp_t;
   typedef struct packed { op_t op; exp_t e; } vec_t;
   typedef struct packed {
      logic saw_req; logic [31:0] req_addr; logic req_wen; logic [31:0] req_wdata;
      logic [7:0] req_wmask; logic got_wb; logic wb_wen; logic [4:0] wb_waddr;
      logic [31:0] wb_wdata; logic wb_err; logic unstable; logic rdy_high; logic rdy_after;
      logic overlap; int wb_cyc;
   } res_t;

   int n_pass = 0, n_total = 0;
   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endtask

   function automatic op_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] waddr, input logic [31:0] rdata,
                              input int rq, input int rs, input int wb, input logic early);
      op_t o;
      o.ld = ld; o.st = st; o.f3 = f3; o.addr = addr; o.wdata = wdata; o.waddr = waddr;
      o.rdata = rdata; o.req_dly = rq; o.resp_dly = rs; o.wb_dly = wb; o.early = early;
      return o;
   endfunction

   function automatic exp_t ex(input logic req, input logic [31:0] maddr, input logic mwen,
                               input logic [31:0] mwdata, input logic [7:0] mmask,
                               input logic err, input logic wwen, input logic [31:0] wdata);
      exp_t e;
      e.req = req; e.maddr = maddr; e.mwen = mwen; e.mwdata = mwdata; e.mmask = mmask;
      e.err = err; e.wwen = wwen; e.wdata = wdata;
      return e;
   endfunction

   // Reference model: access size, legality and lane arithmetic straight from the ISA rules.
   function automatic exp_t model(input op_t op);
      exp_t e;
      int lo, sz;
      longint unsigned p, q, lane, w;
      bit legal;
      e = '0;
      lo = int'(op.addr % 32'd4);
      sz = (op.f3 % 4 == 0) ? 1 : (op.f3 % 4 == 1) ? 2 : 4;
      if (op.ld && op.st) legal = 0;
      else if (op.ld) legal = (op.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      else legal = (op.f3 inside {3'd0, 3'd1, 3'd2});
      if (lo % sz != 0) legal = 0;
      p = 1; repeat (lo) p = p * 256;
      q = 1; repeat (sz) q = q * 256;
      e.err = !legal;
      e.req = legal;
      if (legal) begin
         e.maddr = op.addr - 32'(lo);
         e.mwen = op.st;
         if (op.st) begin
            w = op.wdata;
            e.mmask = 8'((2 ** sz - 1) * (2 ** lo));
            e.mwdata = 32'(w * p);
         end else begin
            w = op.rdata;
            lane = (w / p) % q;
            if (op.f3 < 3'd4 && sz < 4 && lane >= q / 2) lane = lane + (64'h1_0000_0000 - q);
            e.wdata = 32'(lane);
            e.wwen = (op.waddr != 5'd0);
         end
      end
      return e;
   endfunction

   // Drives one op from IDLE and plays memory/writeback; called and returns on a negedge.
   task automatic run_op(input op_t op, output res_t r);
      int req_cnt, wait_cnt, wb_cnt;
      bit in_wait, done;
      req_cnt = 0; wait_cnt = 0; wb_cnt = 0; in_wait = 0; done = 0;
      r = '0;
      r.wb_cyc = -1;
      in_valid = 1'b1; in_is_load = op.ld; in_is_store = op.st; in_func3 = op.f3;
      in_addr = op.addr; in_wdata = op.wdata; in_waddr = op.waddr;
      @(negedge clk);
      in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         mem_req_ready = 1'b0; mem_resp_valid = 1'b0; wb_ready = 1'b0;
         if (in_ready) r.rdy_high = 1'b1;
         if (mem_req_valid && wb_valid) r.overlap = 1'b1;
         if (in_wait) begin
            if (wait_cnt == op.resp_dly) begin
               mem_resp_valid = 1'b1; mem_rdata = op.rdata; in_wait = 0;
            end
            wait_cnt++;
         end
         if (mem_req_valid) begin
            if (!r.saw_req) begin
               r.saw_req = 1'b1; r.req_addr = mem_addr; r.req_wen = mem_wen;
               r.req_wdata = mem_wdata; r.req_wmask = mem_wmask;
            end else if ({mem_wen, mem_addr, mem_wdata, mem_wmask} !==
                         {r.req_wen, r.req_addr, r.req_wdata, r.req_wmask}) begin
               r.unstable = 1'b1;
            end
            if (req_cnt >= op.req_dly) begin
               mem_req_ready = 1'b1; in_wait = 1;
               if (op.early) begin mem_resp_valid = 1'b1; mem_rdata = 32'h1111_1111; end
            end
            req_cnt++;
         end
         if (wb_valid) begin
            if (!r.got_wb) begin
               r.got_wb = 1'b1; r.wb_cyc = cyc; r.wb_wen = wb_wen; r.wb_waddr = wb_waddr;
               r.wb_wdata = wb_wdata; r.wb_err = wb_err;
            end else if ({wb_wen, wb_waddr, wb_wdata, wb_err} !==
                         {r.wb_wen, r.wb_waddr, r.wb_wdata, r.wb_err}) begin
               r.unstable = 1'b1;
            end
            if (wb_cnt >= op.wb_dly) begin wb_ready = 1'b1; done = 1; end
            wb_cnt++;
         end
         @(negedge clk);
      end
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; wb_ready = 1'b0;
      r.rdy_after = in_ready;
   endtask

   task automatic check_op(input string tag, input op_t op, input exp_t e, input res_t r);
      check({tag, " mem_req_seen"}, 32'(r.saw_req), 32'(e.req));
      if (e.req) begin
         check({tag, " mem_addr"}, r.req_addr, e.maddr);
         check({tag, " mem_wen"}, 32'(r.req_wen), 32'(e.mwen));
         if (op.st) begin
            check({tag, " mem_wdata"}, r.req_wdata, e.mwdata);
            check({tag, " mem_wmask"}, 32'(r.req_wmask), 32'(e.mmask));
         end
      end
      check({tag, " wb_seen"}, 32'(r.got_wb), 32'd1);
      check({tag, " wb_err"}, 32'(r.wb_err), 32'(e.err));
      check({tag, " wb_wen"}, 32'(r.wb_wen), 32'(e.wwen));
      check({tag, " wb_waddr"}, 32'(r.wb_waddr), 32'(op.waddr));
      if (!e.err && op.ld) check({tag, " wb_wdata"}, r.wb_wdata, e.wdata);
      check({tag, " wb_latency"}, 32'(r.wb_cyc), e.err ? 32'd0 : 32'(2 + op.req_dly + op.resp_dly));
      check({tag, " payload_stable"}, 32'(r.unstable), 32'd0);
      check({tag, " in_ready_low"}, 32'(r.rdy_high), 32'd0);
      check({tag, " in_ready_after"}, 32'(r.rdy_after), 32'd1);
      check({tag, " req_wb_overlap"}, 32'(r.overlap), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " ctrl"}, 32'({in_ready, mem_req_valid, mem_wen, mem_wmask, wb_valid, wb_wen,
                                 wb_err, wb_waddr}), 32'({1'b1, 18'd0}));
      check({tag, " mem_addr"}, mem_addr, 32'd0);
      check({tag, " mem_wdata"}, mem_wdata, 32'd0);
      check({tag, " wb_wdata"}, wb_wdata, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

   initial begin
      op_t op;
      exp_t e;
      res_t r;
      bit stray;
      logic [2:0] lf[5];
      lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

      vecs[0]  = '{mk(1,0,3'b010,32'h8000_0004,0,5,32'hDEAD_BEEF,0,2,0,0), ex(1,32'h8000_0004,0,0,0,0,1,32'hDEAD_BEEF)};
      vecs[1]  = '{mk(1,0,3'b000,32'h0000_0103,0,7,32'h8000_0000,0,0,0,0), ex(1,32'h100,0,0,0,0,1,32'hFFFF_FF80)};
      vecs[2]  = '{mk(1,0,3'b100,32'h0000_0103,0,7,32'h8000_0000,0,0,0,0), ex(1,32'h100,0,0,0,0,1,32'h0000_0080)};
      vecs[3]  = '{mk(1,0,3'b101,32'h0000_0102,0,7,32'hABCD_0000,1,0,1,0), ex(1,32'h100,0,0,0,0,1,32'h0000_ABCD)};
      vecs[4]  = '{mk(0,1,3'b000,32'h0000_2001,32'h1234_56AA,3,0,0,0,0,0), ex(1,32'h2000,1,32'h3456_AA00,8'h02,0,0,0)};
      vecs[5]  = '{mk(0,1,3'b001,32'h0000_2002,32'h1234_56AA,3,0,0,1,0,0), ex(1,32'h2000,1,32'h56AA_0000,8'h0C,0,0,0)};
      vecs[6]  = '{mk(1,0,3'b010,32'h0000_3002,0,6,0,0,0,0,0), ex(0,0,0,0,0,1,0,0)};
      vecs[7]  = '{mk(0,1,3'b001,32'h0000_3001,32'h55,6,0,0,0,1,0), ex(0,0,0,0,0,1,0,0)};
      vecs[8]  = '{mk(1,1,3'b010,32'h0000_0040,0,6,0,0,0,0,0), ex(0,0,0,0,0,1,0,0)};
      vecs[9]  = '{mk(1,0,3'b011,32'h0000_0040,0,6,0,0,0,0,0), ex(0,0,0,0,0,1,0,0)};
      vecs[10] = '{mk(1,0,3'b010,32'h0000_0044,0,0,32'h1234_5678,0,1,0,0), ex(1,32'h44,0,0,0,0,0,32'h1234_5678)};
      vecs[11] = '{mk(1,0,3'b001,32'h0000_0106,0,9,32'h8001_0000,0,0,0,0), ex(1,32'h104,0,0,0,0,1,32'hFFFF_8001)};
      vecs[12] = '{mk(0,1,3'b010,32'h0000_0400,32'hCAFE_F00D,2,0,5,1,3,0), ex(1,32'h400,1,32'hCAFE_F00D,8'h0F,0,0,0)};
      vecs[13] = '{mk(1,0,3'b010,32'h0000_0500,0,8,32'h0BAD_CAFE,0,1,0,1), ex(1,32'h500,0,0,0,0,1,32'h0BAD_CAFE)};

      // Reset block
      repeat (2) @(negedge clk);
      #1 check_reset_outputs("reset_state");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // An offer with neither load nor store must be ignored.
      in_valid = 1'b1; in_func3 = 3'b010; in_addr = 32'h10;
      @(negedge clk);
      @(negedge clk);
      check("noop_ignored", 32'({in_ready, mem_req_valid, wb_valid}), 32'b100);
      in_valid = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         run_op(vecs[i].op, r);
         check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].e, r);
      end

      for (int i = 0; i < 80; i++) begin
         int k;
         op = '0;
         k = $urandom_range(0, 9);
         if (k == 0) begin op.ld = 1; op.st = 1; end
         else if (k < 6) op.ld = 1;
         else op.st = 1;
         if ($urandom_range(0, 3) == 0) op.f3 = 3'($urandom_range(0, 7));
         else op.f3 = op.ld ? lf[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
         op.addr = $urandom;
         op.wdata = $urandom;
         op.rdata = $urandom;
         op.waddr = 5'($urandom_range(0, 31));
         op.req_dly = $urandom_range(0, 2);
         op.resp_dly = $urandom_range(0, 2);
         op.wb_dly = $urandom_range(0, 2);
         op.early = 1'($urandom_range(0, 1));
         e = model(op);
         run_op(op, r);
         check_op($sformatf("rand%0d", i), op, e, r);
      end

      // Timeout in WAIT: no response ever arrives.
      run_op(mk(1,0,3'b010,32'h0000_0600,0,4,0,0,1000,0,0), r);
      check("to_wait seen", 32'({r.saw_req, r.got_wb, r.wb_err, r.wb_wen}), 32'b1110);
      check("to_wait latency", 32'(r.wb_cyc), 32'(TO));
      check("to_wait in_ready_after", 32'(r.rdy_after), 32'd1);
      mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      stray = 0;
      repeat (4) begin
         if (wb_valid || mem_req_valid || !in_ready) stray = 1;
         @(negedge clk);
      end
      check("late_resp_ignored", 32'(stray), 32'd0);

      // Timeout in REQ: memory never accepts; request must drop as the error is raised.
      run_op(mk(0,1,3'b010,32'h0000_0700,32'h1,4,0,1000,0,0,0), r);
      check("to_req seen", 32'({r.saw_req, r.got_wb, r.wb_err, r.wb_wen}), 32'b1110);
      check("to_req latency", 32'(r.wb_cyc), 32'(TO));
      check("to_req overlap", 32'(r.overlap), 32'd0);

      // Reset while waiting for a response.
      in_valid = 1'b1; in_is_load = 1'b1; in_func3 = 3'b010; in_addr = 32'h0000_0604; in_waddr = 5'd4;
      @(negedge clk);
      in_valid = 1'b0; in_is_load = 1'b0;
      check("rst_seq req_valid", 32'(mem_req_valid), 32'd1);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1 check_reset_outputs("reset_in_wait");
      @(negedge clk);
      rst = 1'b0;
      mem_resp_valid = 1'b1; mem_rdata = 32'h7777_7777;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      stray = 0;
      repeat (6) begin
         if (wb_valid || mem_req_valid || !in_ready) stray = 1;
         @(negedge clk);
      end
      check("post_reset_quiet", 32'(stray), 32'd0);

      op = mk(1,0,3'b100,32'h0000_0701,0,12,32'h0000_F100,1,1,1,0);
      run_op(op, r);
      check_op("post_reset_op", op, model(op), r);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ysyx_23060332_lsu.md
Name: ysyx_23060332_lsu

Overview:
Load/store unit directly downstream of the execute stage. It accepts one decoded memory operation at a time (address already computed by execute) and drives a valid/ready memory bus. It handles byte/half/word lane alignment, load sign/zero extension and misalignment detection, then hands a writeback result to the register file stage. Loads and stores are multi-cycle.

Parameters:
TIMEOUT_CYC, 255, cycles allowed in REQ+WAIT before aborting with error; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  execute presents an operation
in_ready  out  1  LSU can accept (high only in IDLE)
in_is_load  in  1  operation is a load
in_is_store  in  1  operation is a store (in_is_load and in_is_store both high = illegal)
in_func3  in  3  RISC-V funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW)
in_addr  in  32  effective byte address
in_wdata  in  32  store data (rs2), unshifted
in_waddr  in  5  load destination register
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_wen  out  1  1 = write, 0 = read
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_wdata  out  32  lane-shifted store data
mem_wmask  out  8  byte mask; [3:0] lanes, [7:4] always 0
mem_resp_valid  in  1  memory response (read data or write ack), one-cycle pulse
mem_rdata  in  32  read word
wb_valid  out  1  completion valid
wb_ready  in  1  writeback consumes
wb_wen  out  1  register write enable
wb_waddr  out  5  destination register
wb_wdata  out  32  extended load data
wb_err  out  1  misaligned / illegal / timeout

Behaviour:
- All outputs registered. On reset, in any state: state=IDLE; in_ready=1; mem_req_valid=0, mem_wen=0, mem_addr=0, mem_wdata=0, mem_wmask=0; wb_valid=0, wb_wen=0, wb_waddr=0, wb_wdata=0, wb_err=0; watchdog=0.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: in_ready=1. On in_valid&&in_ready, latch the operation. If legal and aligned -> REQ. Otherwise -> RESP with wb_err=1, wb_wen=0, and no memory access. Operations with neither load nor store set are ignored (stay IDLE).
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0. Illegal: funct3 not listed above, or both load and store set.
- REQ: mem_req_valid=1 and payload held stable until mem_req_ready; on the handshake edge -> WAIT.
  - Store: mask = 0001/0011/1111 shifted left by addr[1:0]; wdata shifted left by 8*addr[1:0].
- WAIT: mem_resp_valid is sampled only in WAIT; a response in the same cycle as the request handshake is a protocol violation and is ignored. On mem_resp_valid -> RESP.
  - Load: shift rdata right by 8*addr[1:0], then extend. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
  - Load result: wb_wen=1 when waddr!=0, else 0.
  - Store result: wb_wen=0.
- RESP: wb_valid=1 with the payload stable until wb_ready; on the handshake edge -> IDLE. in_ready returns high the following cycle.
- Minimum accept-to-wb_valid latency, legal op: accept edge at cycle 0 -> mem_req_valid in cycle 1 -> response no earlier than cycle 2 -> wb_valid in cycle 3.
- Watchdog:
  - Counts every cycle spent in REQ or WAIT; cleared on entering REQ.
  - Reaching TIMEOUT_CYC -> RESP with wb_err=1, wb_wen=0, mem_req_valid dropped.
  - A late mem_resp_valid after the abort is ignored.
- Reset during REQ/WAIT aborts the operation; no wb_valid is produced for it; a stale response arriving after reset is ignored.

Test Plan:
- LW at 0x8000_0004, mem returns 0xDEAD_BEEF after 2 wait cycles, waddr=5 -> mem_addr=0x8000_0004, mem_wen=0; wb_valid with wb_wen=1, wb_waddr=5, wb_wdata=0xDEAD_BEEF, wb_err=0.
- LB at 0x103, rdata 0x8000_0000 -> wb_wdata=0xFFFF_FF80; LBU at the same address -> 0x0000_0080; LHU at 0x102, rdata 0xABCD_0000 -> 0x0000_ABCD.
- SB at 0x2001 with wdata 0x1234_56AA -> mem_addr=0x2000, mem_wmask=8'h02, mem_wdata=0x3456_AA00; SH at 0x2002 -> mask 8'h0C; completion has wb_wen=0.
- LW at 0x3002 -> no mem_req_valid at any cycle; wb_valid with wb_err=1, wb_wen=0; SH at 0x3001 gives the same result.
- Back-pressure: mem_req_ready held low 5 cycles, then wb_ready held low 3 cycles -> mem payload and wb payload held stable throughout; in_ready stays low until the cycle after the wb handshake.
- TIMEOUT_CYC=8 with no mem_resp_valid -> wb_err=1 within 8 cycles of entering REQ; a response injected afterwards is ignored. Separately, assert rst while in WAIT -> all outputs return to reset values immediately and no wb_valid follows.
